instr_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction decoder (cpuControl).

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch/decode front end.
// Also holds the branch-offset helper used by the redirect target adder.
package cpu_pkg;

    localparam logic [15:0] NOP_INSTR = 16'hBF00;

    localparam logic [1:0] BR_SEQ  = 2'b11;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_UNC  = 2'b10;
    localparam logic [1:0] BR_LINK = 2'b00;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

    // Sign-extended branch offset; the immediate width depends on the branch kind
    function automatic logic [15:0] br_offset(input logic [1:0] sel, input logic [15:0] instr);
        logic [15:0] off;
        off = '0;
        case (sel)
            BR_COND: off = {{8{instr[7]}}, instr[7:0]};
            BR_UNC:  off = {{5{instr[10]}}, instr[10:0]};
            BR_LINK: off = {{10{instr[5]}}, instr[5:0]};
            default: off = '0;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used for the prefetch buffer and the
// in-flight request PC queue. Flush takes priority over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type T = logic [15:0]
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  T                             i_data,
    input  logic                         i_pop,
    output T                             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= ptr_inc(r_wr);
            if (i_pop)  r_rd <= ptr_inc(r_rd);
            r_count <= CW'(r_count + CW'(i_push) - CW'(i_pop));
        end
    end

    // Storage needs no reset: entries are only observed while counted valid
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem request issue, prefetch buffering and
// branch/BX redirect handling with a drain of stale in-flight responses.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    input  logic        redir_valid,
    input  logic [1:0]  redir_brSel,
    input  logic        redir_brEx,
    input  logic [15:0] redir_pc,
    input  logic [15:0] redir_instr,
    input  logic [15:0] redir_reg
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t        r_state;
    logic [15:0]   r_pc;
    logic          w_redir_taken;
    logic          w_grant;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [15:0]   w_target;
    logic [15:0]   w_req_pc;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_inflight_next;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;

    assign w_redir_taken = redir_valid && (redir_brEx || (redir_brSel != BR_SEQ));
    assign w_target      = redir_brEx ? redir_reg
                                      : redir_pc + 16'd1 + br_offset(redir_brSel, redir_instr);

    // Fetch only while the buffer plus outstanding requests leave room for the reply
    assign imem_req  = !reset && (r_state == ST_RUN) && !w_redir_taken &&
                       ((SW'(w_count) + SW'(w_inflight)) < SW'(DEPTH));
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;

    // The in-flight count is the occupancy of the request-PC queue
    assign w_rsp           = imem_rvalid && (w_inflight != '0);
    assign w_inflight_next = CW'(w_inflight + CW'(w_grant) - CW'(w_rsp));
    assign w_push          = w_rsp && (r_state == ST_RUN) && !w_redir_taken;
    assign w_push_entry    = '{pc: w_req_pc, instr: imem_rdata};

    assign w_empty  = (w_count == '0);
    assign if_valid = !w_empty && !w_redir_taken;
    assign w_pop    = if_valid && id_ready;
    assign if_instr = if_valid ? w_head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? w_head.pc : 16'h0;

    fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_prefetch (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_redir_taken),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [15:0])) u_pc_queue (
        .clk     (clk),
        .reset   (reset),
        .i_flush (1'b0),
        .i_push  (w_grant),
        .i_data  (r_pc),
        .i_pop   (w_rsp),
        .o_head  (w_req_pc),
        .o_count (w_inflight)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else begin
            if (w_redir_taken) r_pc <= w_target;
            else if (w_grant)  r_pc <= r_pc + 16'd1;

            case (r_state)
                ST_RUN:   if (w_redir_taken && (w_inflight_next != '0)) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_inflight_next == '0) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with random
// grant/latency plus a scoreboard of expected fetch and decode streams.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [15:0] imem_addr, imem_rdata;
    logic        if_valid, id_ready;
    logic [15:0] if_instr, if_pc;
    logic        redir_valid, redir_brEx;
    logic [1:0]  redir_brSel;
    logic [15:0] redir_pc, redir_instr, redir_reg;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .redir_valid (redir_valid),
        .redir_brSel (redir_brSel),
        .redir_brEx  (redir_brEx),
        .redir_pc    (redir_pc),
        .redir_instr (redir_instr),
        .redir_reg   (redir_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        int unsigned due;
        int unsigned epoch;
    } req_t;

    req_t        pend[$];      // granted requests awaiting a memory response
    logic [15:0] buf_q[$];     // PCs expected to reach decode, in order
    logic [15:0] exp_pc;       // address the next granted request must carry
    int unsigned epoch    = 0;
    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned gnt_pct  = 100;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    logic        found;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'd40503) ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] ref_target(input logic brex, input logic [1:0] sel,
                                               input logic [15:0] pc, input logic [15:0] ins,
                                               input logic [15:0] rreg);
        int off;
        if (brex) return rreg;
        case (sel)
            2'b01:   off = int'($signed(ins[7:0]));
            2'b10:   off = int'($signed(ins[10:0]));
            default: off = int'($signed(ins[5:0]));
        endcase
        return 16'(int'(pc) + 1 + off);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_imem_req"}, 32'(imem_req), 32'd0);
        check({pfx, "_if_valid"}, 32'(if_valid), 32'd0);
        check({pfx, "_if_instr"}, 32'(if_instr), 32'(NOP_INSTR));
        check({pfx, "_if_pc"},    32'(if_pc),    32'd0);
        check({pfx, "_imem_addr"}, 32'(imem_addr), 32'(RESET_PC));
    endtask

    // One clock: drive at negedge, check settled outputs, advance the model to the edge
    task automatic run_cycle(input logic rv, input logic [1:0] sel, input logic brex,
                             input logic [15:0] rpc, input logic [15:0] rins,
                             input logic [15:0] rreg, input logic rdy);
        logic taken, stale, exp_req, exp_v;
        req_t r;
        @(negedge clk);
        redir_valid = rv;
        redir_brSel = sel;
        redir_brEx  = brex;
        redir_pc    = rpc;
        redir_instr = rins;
        redir_reg   = rreg;
        id_ready    = rdy;
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].pc);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'($urandom);
        end
        #1;
        taken = rv && (brex || sel != 2'b11);
        stale = 1'b0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale = 1'b1;
        exp_req = !stale && !taken && ((buf_q.size() + pend.size()) < DEPTH);
        exp_v   = !taken && (buf_q.size() > 0);
        check("imem_req",  32'(imem_req),  32'(exp_req));
        check("imem_addr", 32'(imem_addr), 32'(exp_pc));
        check("if_valid",  32'(if_valid),  32'(exp_v));
        check("if_pc",     32'(if_pc),     exp_v ? 32'(buf_q[0]) : 32'd0);
        check("if_instr",  32'(if_instr),  exp_v ? 32'(mem_word(buf_q[0])) : 32'(NOP_INSTR));

        if (exp_v && rdy) void'(buf_q.pop_front());
        if (imem_rvalid) begin
            r = pend.pop_front();
            if (!taken && r.epoch == epoch) buf_q.push_back(r.pc);
        end
        if (taken) begin
            buf_q.delete();
            epoch++;
            exp_pc = ref_target(brex, sel, rpc, rins, rreg);
        end else if (exp_req && imem_gnt) begin
            r.pc    = exp_pc;
            r.due   = cyc + $urandom_range(lat_max, lat_min);
            r.epoch = epoch;
            pend.push_back(r);
            exp_pc++;
        end
        @(posedge clk);
        #1;
        redir_valid = 1'b0;
        cyc++;
    endtask

    task automatic seq_cycle(input logic rdy);
        run_cycle(1'b0, BR_SEQ, 1'b0, 16'h0, 16'h0, 16'h0, rdy);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        redir_valid = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        pend.delete();
        buf_q.delete();
        exp_pc = RESET_PC;
        epoch++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0;
        id_ready    = 1'b0;
        redir_valid = 1'b0;
        redir_brSel = BR_SEQ;
        redir_brEx  = 1'b0;
        redir_pc    = 16'h0;
        redir_instr = 16'h0;
        redir_reg   = 16'h0;
        exp_pc      = RESET_PC;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming with 1-cycle memory and an always-ready decoder
        repeat (12) seq_cycle(1'b1);

        // Decode stall: buffer fills, requests stop, then resume in order
        repeat (5) seq_cycle(1'b0);
        repeat (8) seq_cycle(1'b1);

        // Conditional branch with one request still outstanding
        lat_min = 2;
        lat_max = 2;
        found   = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (pend.size() == 1 && pend[0].due == cyc + 1) begin
                found = 1'b1;
                break;
            end
            seq_cycle(1'b1);
        end
        check("t3_setup", 32'(found), 32'd1);
        if (found) begin
            run_cycle(1'b1, BR_COND, 1'b0, 16'h0010, 16'h00FC, 16'h0, 1'b1);
            check("t3_drain_req", 32'(imem_req), 32'd0);
            check("t3_addr", 32'(imem_addr), 32'h000D);
        end
        repeat (8) seq_cycle(1'b1);

        // BX while the buffer is full and decode is ready
        lat_min = 1;
        lat_max = 1;
        found   = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (buf_q.size() == DEPTH && pend.size() == 0) begin
                found = 1'b1;
                break;
            end
            seq_cycle(1'b0);
        end
        check("t4_setup", 32'(found), 32'd1);
        run_cycle(1'b1, BR_SEQ, 1'b1, 16'h0, 16'h0, 16'h1234, 1'b1);
        check("t4_empty", 32'(if_valid), 32'd0);
        check("t4_addr", 32'(imem_addr), 32'h1234);
        repeat (6) seq_cycle(1'b1);

        // PC wrap at 16'hFFFF, then a B from 16'hFFFF with zero offset
        run_cycle(1'b1, BR_SEQ, 1'b1, 16'h0, 16'h0, 16'hFFFD, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            seq_cycle(1'b1);
            if (exp_pc == 16'h0000) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_setup", 32'(found), 32'd1);
        check("t5_wrap", 32'(imem_addr), 32'h0000);
        repeat (4) seq_cycle(1'b1);
        run_cycle(1'b1, BR_UNC, 1'b0, 16'hFFFF, 16'hE000, 16'h0, 1'b1);
        check("t5_b", 32'(imem_addr), 32'h0000);
        repeat (4) seq_cycle(1'b1);

        // Reset in the middle of traffic with buffered and outstanding fetches
        lat_min = 3;
        lat_max = 3;
        repeat (3) seq_cycle(1'b0);
        mid_reset();
        check("t6_addr", 32'(imem_addr), 32'(RESET_PC));
        repeat (6) seq_cycle(1'b1);

        // Random traffic with random redirects (taken and not taken)
        gnt_pct = 70;
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) mid_reset();
            if ($urandom_range(99) < 6)
                run_cycle(1'b1, 2'($urandom_range(3)), ($urandom_range(3) == 0),
                          16'($urandom), 16'($urandom), 16'($urandom),
                          ($urandom_range(99) < 70));
            else
                seq_cycle($urandom_range(99) < 70);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
